// File: rtl/sigma_delta_audio.sv
// sigma_delta_audio: 10-bit unsigned audio sample -> 1-bit second-order
// sigma-delta pulse-density stream. An optional DC-blocking high-pass stage
// sits in front of the modulator and is built only when AUDIO_DC_BLOCK_EN is
// defined; otherwise samples pass straight to the modulator with 1-cycle latency.
module sigma_delta_audio #(
  parameter int unsigned IN_W     = 10,
  parameter int unsigned DC_SHIFT = 10,
  parameter int unsigned INT_W    = IN_W + 4
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_sample,
  output logic            in_ready,
  input  logic            mute,
  output logic            overrun,
  output logic            out_bit
);

  localparam int unsigned SUM_W = INT_W + 2;
  localparam logic signed [SUM_W-1:0] FB_MAG  = SUM_W'(2 ** (IN_W - 1));
  localparam logic signed [SUM_W-1:0] INT_MAX = SUM_W'((2 ** (INT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] INT_MIN = -INT_MAX - SUM_W'(1);

  // Reject parameterisations the datapath cannot represent
  if (IN_W < 2 || DC_SHIFT < 1 || INT_W < IN_W + 2) begin : g_bad_params
    $error("sigma_delta_audio: unsupported parameter set");
  end

  // Offset-binary to two's complement: subtracting mid-scale flips the MSB
  logic signed [IN_W-1:0] x_s_c;
  assign x_s_c = {~in_sample[IN_W-1], in_sample[IN_W-2:0]};

  logic signed [IN_W-1:0] mod_in;

`ifdef AUDIO_DC_BLOCK_EN
  localparam int unsigned ACC_W = IN_W + DC_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_DIFF, S_UPDATE} state_t;
  state_t state, state_next;

  logic signed [IN_W-1:0]  x_q;
  logic signed [IN_W:0]    diff_q;
  logic signed [IN_W:0]    diff_c;
  logic signed [ACC_W-1:0] dc_acc;
  logic signed [IN_W-1:0]  dc_int_c;
  logic signed [IN_W-1:0]  y_c;
  logic                    accept_c;

  // Integer part of the DC estimate and the high-pass difference
  assign dc_int_c = dc_acc[ACC_W-1:DC_SHIFT];
  assign diff_c   = (IN_W+1)'(x_q) - (IN_W+1)'(dc_int_c);

  // Clamp the (IN_W+1)-bit difference back into the signed sample range
  always_comb begin
    y_c = diff_q[IN_W-1:0];
    if (diff_q[IN_W] != diff_q[IN_W-1]) begin
      y_c = diff_q[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state: accept in IDLE, then one cycle each for DIFF and UPDATE
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = S_DIFF;
        end
      end
      S_DIFF:   state_next = S_UPDATE;
      S_UPDATE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // DC-blocker datapath, handshake and sticky overrun flag
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      x_q      <= '0;
      diff_q   <= '0;
      dc_acc   <= '0;
      mod_in   <= '0;
      in_ready <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      in_ready <= (state_next == S_IDLE);
      if (in_valid && !in_ready) overrun <= 1'b1;
      if (accept_c) x_q <= x_s_c;
      if (state == S_DIFF) diff_q <= diff_c;
      if (state == S_UPDATE) begin
        dc_acc <= dc_acc + ACC_W'(diff_q);
        mod_in <= y_c;
      end
    end
  end
`else
  assign in_ready = 1'b1;
  assign overrun  = 1'b0;

  // Pass-through: register the converted sample whenever it is offered
  always_ff @(posedge clk_sys) begin
    if (reset)         mod_in <= '0;
    else if (in_valid) mod_in <= x_s_c;
  end
`endif

  // Clamp a wide sum to the signed integrator range
  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [SUM_W-1:0] v);
    if (v > INT_MAX)      return INT_MAX[INT_W-1:0];
    else if (v < INT_MIN) return INT_MIN[INT_W-1:0];
    else                  return v[INT_W-1:0];
  endfunction

  logic signed [IN_W-1:0]  m_c;
  logic signed [SUM_W-1:0] fb_c;
  logic signed [INT_W-1:0] int1, int2;
  logic signed [INT_W-1:0] int1_next_c, int2_next_c;

  // Second-order loop: both integrators see the previous output as feedback
  assign m_c         = mute ? '0 : mod_in;
  assign fb_c        = out_bit ? FB_MAG : -FB_MAG;
  assign int1_next_c = sat_int(SUM_W'(int1) + SUM_W'(m_c) - fb_c);
  assign int2_next_c = sat_int(SUM_W'(int2) + SUM_W'(int1) - fb_c);

  // Modulator state, updated every clock
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      int1    <= '0;
      int2    <= '0;
      out_bit <= 1'b0;
    end else begin
      int1    <= int1_next_c;
      int2    <= int2_next_c;
      out_bit <= ~int2_next_c[INT_W-1];
    end
  end

endmodule
